spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Single-clock SPI master: serialises an 8-bit word on MOSI and captures 8 bits from MISO, MSB first, one bit per clk cycle.
- Drives one of four active-low slave selects chosen by slave_sel.
- Sits between a host-side register interface (read_en/write_en/data_in/data_out) and up to four SPI slaves.

Parameters:
- WIDTH, 8, transfer word length in bits; bit counter sized clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock; also the SPI bit clock
- rst  input  1  asynchronous, active-high reset
- read_en  input  1  request a transfer that shifts out 0x00 and captures MISO
- write_en  input  1  request a transfer that shifts out data_in (MISO captured as well)
- MISO  input  1  serial data from selected slave
- slave_sel  input  2  target slave: 0->SS_1, 1->SS_2, 2->SS_3, 3->SS_4
- data_in  input  WIDTH  word to transmit
- MOSI  output  1  serial data to slaves, MSB first
- SS_1..SS_4  output  1 each  active-low slave selects
- sclk  output  1  SPI clock; low when idle
- data_out  output  WIDTH  last received word

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, SS_1..SS_4=1, MOSI=0, sclk=0, data_out=0, shift registers and counter=0.
  - Reset mid-transfer aborts immediately; no partial data_out update.
- States: IDLE, SHIFT, DONE, HOLD.
- IDLE:
  - At posedge with write_en=1 or read_en=1: latch slave_sel into sel_q, load tx_shift (data_in if write_en=1, else 0x00), clear rx_shift, counter=0, go to SHIFT.
  - write_en has priority when both enables are high; data_in is still transmitted.
  - Same edge: selected SS driven 0, MOSI = first tx bit.
- SHIFT (exactly WIDTH cycles):
  - Each posedge: rx_shift <= {rx_shift[WIDTH-2:0], MISO}; tx_shift shifts left; MOSI = next MSB; counter++.
  - After the WIDTH-th sample go to DONE.
  - slave_sel/data_in changes during SHIFT are ignored (sel_q latched).
- sclk:
  - In SHIFT, sclk = ~clk gated by the registered shift-active flag (glitch-free AND).
  - sclk rises mid-bit (clk negedge); slave samples MOSI there. Mode 0 equivalent.
  - Master samples MISO on clk posedge at end of each bit.
  - 0 in all other states.
- DONE (1 cycle):
  - data_out <= rx_shift (complete word), all SS=1, MOSI=0.
  - Go to HOLD.
- HOLD:
  - Stay while write_en or read_en is high; return to IDLE when both are low.
  - A held enable therefore produces exactly one transfer.
- Latency: request edge -> data_out valid = WIDTH+1 posedges (9 for WIDTH=8).
- Only one SS low at any time; all high outside SHIFT.
- data_out holds its value until the next DONE.

Decomposition:
- Package spi_pkg: state enum (IDLE, SHIFT, DONE, HOLD), WIDTH default constant.
- Optional sub-module spi_ss_decoder (2-bit sel + enable -> 4 active-low selects).
- FSM and shifters stay in spi_master.

Test Plan:
- Reset: rst=1 for 1 cycle -> SS_1..4=1, MOSI=0, sclk=0, data_out=0x00.
- Write: slave_sel=2, data_in=8'b00001101, write_en held 10 cycles -> SS_3 low for exactly 8 cycles; MOSI sequence 0,0,0,0,1,1,0,1; 8 sclk pulses; single transfer only (HOLD), SS_3 high after.
- Read: read_en=1, slave_sel=1, MISO driven 1,0,1,1,0,0,1,0 one bit per clk -> SS_2 low 8 cycles; MOSI=0 throughout; data_out=0xB2 at 9th posedge.
- Both enables high with data_in=0xA5, MISO=1 constant -> MOSI shows 0xA5 bitwise; data_out=0xFF.
- Reset asserted at bit 4 of a transfer -> immediate SS all high, sclk=0, data_out keeps reset value 0x00; new transfer after release works.
- Sequence of slave_sel=0,3 transfers -> only SS_1 then only SS_4 ever low; slave_sel changed mid-transfer does not move SS.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Brief   : Shared types and constants for the SPI master slice.
// Revision: 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_NUM_SLAVES    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // Bit counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int spi_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ss_decoder.sv
`default_nettype none
// ============================================================================
// Module  : spi_ss_decoder
// Brief   : 2-bit slave index plus enable to four active-low slave selects.
// Revision: 1.0 - initial release
// ============================================================================
module spi_ss_decoder
    import spi_pkg::*;
(
    input  logic [1:0]              i_sel,
    input  logic                    i_en,
    output logic [c_NUM_SLAVES-1:0] o_ss_n
);

    genvar i;
    generate
        for (i = 0; i < c_NUM_SLAVES; i++) begin : g_ss
            assign o_ss_n[i] = ~(i_en && (i_sel == 2'(i)));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module  : spi_master
// Brief   : Single-clock SPI master, MSB first, one bit per clk, mode-0 sclk.
// Revision: 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_en,
    input  logic             write_en,
    input  logic             MISO,
    input  logic [1:0]       slave_sel,
    input  logic [WIDTH-1:0] data_in,
    output logic             MOSI,
    output logic             SS_1,
    output logic             SS_2,
    output logic             SS_3,
    output logic             SS_4,
    output logic             sclk,
    output logic [WIDTH-1:0] data_out
);

    localparam int c_CW = spi_cnt_width(WIDTH);

    spi_state_t       r_state;
    spi_state_t       w_next;

    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_data_out;
    logic [c_CW-1:0]  r_cnt;
    logic [1:0]       r_sel;
    logic             r_shift_active;
    logic             r_mosi;

    logic             w_req;
    logic             w_last;
    logic             w_load;
    logic             w_shift;
    logic             w_capture;
    logic             w_active_d;
    logic             w_mosi_d;
    logic [WIDTH-1:0] w_tx_init;
    logic [3:0]       w_ss_n;

    assign w_req     = write_en | read_en;
    assign w_last    = (r_cnt == c_CW'(WIDTH - 1));
    assign w_tx_init = write_en ? data_in : '0;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req)  w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:                w_next = HOLD;
            HOLD:    if (!w_req) w_next = IDLE;
            default:             w_next = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_capture  = 1'b0;
        w_active_d = 1'b0;
        w_mosi_d   = 1'b0;
        case (r_state)
            IDLE: begin
                w_load     = w_req;
                w_active_d = w_req;
                w_mosi_d   = w_req & w_tx_init[WIDTH-1];
            end
            SHIFT: begin
                w_shift    = 1'b1;
                w_active_d = ~w_last;
                // r_tx still holds the current bit at its MSB; present the next one.
                w_mosi_d   = ~w_last & r_tx[WIDTH-2];
            end
            DONE: begin
                w_capture  = 1'b1;
            end
            default: begin
                w_load     = 1'b0;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx           <= '0;
            r_rx           <= '0;
            r_cnt          <= '0;
            r_sel          <= '0;
            r_data_out     <= '0;
            r_shift_active <= 1'b0;
            r_mosi         <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx  <= w_tx_init;
                r_rx  <= '0;
                r_cnt <= '0;
                r_sel <= slave_sel;
            end else if (w_shift) begin
                r_rx  <= {r_rx[WIDTH-2:0], MISO};
                r_tx  <= r_tx << 1;
                r_cnt <= r_cnt + c_CW'(1);
            end
            if (w_capture) begin
                r_data_out <= r_rx;
            end
            r_shift_active <= w_active_d;
            r_mosi         <= w_mosi_d;
        end
    end

    spi_ss_decoder u_ss_dec (
        .i_sel  (r_sel),
        .i_en   (r_shift_active),
        .o_ss_n (w_ss_n)
    );

    // Active flag only changes at posedge, when ~clk is already falling.
    assign sclk     = ~clk & r_shift_active;
    assign MOSI     = r_mosi;
    assign SS_1     = w_ss_n[0];
    assign SS_2     = w_ss_n[1];
    assign SS_3     = w_ss_n[2];
    assign SS_4     = w_ss_n[3];
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master
// Brief   : Scoreboard-driven self-checking bench for spi_master.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       read_en;
    logic       write_en;
    logic       MISO;
    logic [1:0] slave_sel;
    logic [7:0] data_in;
    logic       MOSI;
    logic       SS_1, SS_2, SS_3, SS_4;
    logic       sclk;
    logic [7:0] data_out;

    int n_pass  = 0;
    int n_total = 0;
    int sclk_pulses = 0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    logic [7:0] obs_mosi;
    logic [7:0] obs_dout8;
    logic [7:0] obs_dout9;
    int         obs_tgt_low;
    int         obs_other_low;
    int         obs_pulses;

    spi_master #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .read_en   (read_en),
        .write_en  (write_en),
        .MISO      (MISO),
        .slave_sel (slave_sel),
        .data_in   (data_in),
        .MOSI      (MOSI),
        .SS_1      (SS_1),
        .SS_2      (SS_2),
        .SS_3      (SS_3),
        .SS_4      (SS_4),
        .sclk      (sclk),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    always @(posedge sclk) sclk_pulses <= sclk_pulses + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // Drives one transfer and records what the pins did over a 16-cycle window.
    task automatic do_transfer(input logic [1:0] sel, input logic [7:0] din,
                               input logic we, input logic re,
                               input logic [7:0] miso_w, input int hold, input bit chg);
        logic [3:0] ss;
        int base;
        obs_mosi      = '0;
        obs_tgt_low   = 0;
        obs_other_low = 0;
        slave_sel = sel;
        data_in   = din;
        write_en  = we;
        read_en   = re;
        MISO      = 1'b0;
        base      = sclk_pulses;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            ss = {SS_4, SS_3, SS_2, SS_1};
            if (k < 8) begin
                obs_mosi[7-k] = MOSI;
                MISO          = miso_w[7-k];
            end else begin
                MISO = 1'b0;
            end
            if (ss[sel] == 1'b0) obs_tgt_low++;
            if ((ss | (4'b0001 << sel)) != 4'hF) obs_other_low++;
            if (k == 8) obs_dout8 = data_out;
            if (k == 9) obs_dout9 = data_out;
            if (k == hold - 1) begin
                write_en = 1'b0;
                read_en  = 1'b0;
            end
            if (chg && k == 3) begin
                slave_sel = ~sel;
                data_in   = ~din;
            end
        end
        obs_pulses = sclk_pulses - base;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_total++;
        if ({SS_4, SS_3, SS_2, SS_1} !== 4'hF) $display("FAIL reset_ss: got %b expected 1111", {SS_4, SS_3, SS_2, SS_1});
        else n_pass++;
        n_total++;
        if (MOSI !== 1'b0) $display("FAIL reset_mosi: got %b expected 0", MOSI);
        else n_pass++;
        n_total++;
        if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", sclk);
        else n_pass++;
        n_total++;
        if (data_out !== 8'h00) $display("FAIL reset_dout: got %h expected 00", data_out);
        else n_pass++;
    endtask

    task automatic test_write();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h3C);
        do_transfer(2'd2, 8'b0000_1101, 1'b1, 1'b0, 8'h3C, 10, 1'b0);
        n_total++;
        if (obs_tgt_low !== 8) $display("FAIL write_ss3_low: got %0d cycles expected 8", obs_tgt_low);
        else n_pass++;
        n_total++;
        if (obs_other_low !== 0) $display("FAIL write_other_ss: got %0d cycles expected 0", obs_other_low);
        else n_pass++;
        n_total++;
        if (obs_pulses !== 8) $display("FAIL write_sclk_pulses: got %0d expected 8", obs_pulses);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_mosi !== exp_v) $display("FAIL write_mosi: got %h expected %h", obs_mosi, exp_v);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_dout9 !== exp_v) $display("FAIL write_dout: got %h expected %h", obs_dout9, exp_v);
        else n_pass++;
    endtask

    task automatic test_hold();
        exp_q.push_back(8'h5A);
        do_transfer(2'd0, 8'h5A, 1'b1, 1'b0, 8'h00, 14, 1'b0);
        n_total++;
        if (obs_tgt_low !== 8) $display("FAIL hold_single_xfer: got %0d low cycles expected 8", obs_tgt_low);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_mosi !== exp_v) $display("FAIL hold_mosi: got %h expected %h", obs_mosi, exp_v);
        else n_pass++;
    endtask

    task automatic test_read();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hB2);
        do_transfer(2'd1, 8'hFF, 1'b0, 1'b1, 8'b1011_0010, 1, 1'b0);
        n_total++;
        if (obs_tgt_low !== 8) $display("FAIL read_ss2_low: got %0d cycles expected 8", obs_tgt_low);
        else n_pass++;
        n_total++;
        if (obs_other_low !== 0) $display("FAIL read_other_ss: got %0d cycles expected 0", obs_other_low);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_mosi !== exp_v) $display("FAIL read_mosi: got %h expected %h", obs_mosi, exp_v);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_dout8 !== exp_v) $display("FAIL read_dout_early: got %h expected %h", obs_dout8, exp_v);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_dout9 !== exp_v) $display("FAIL read_dout: got %h expected %h", obs_dout9, exp_v);
        else n_pass++;
    endtask

    task automatic test_both_enables();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hFF);
        do_transfer(2'd3, 8'hA5, 1'b1, 1'b1, 8'hFF, 3, 1'b0);
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_mosi !== exp_v) $display("FAIL both_mosi: got %h expected %h", obs_mosi, exp_v);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_dout8 !== exp_v) $display("FAIL both_dout_held: got %h expected %h", obs_dout8, exp_v);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_dout9 !== exp_v) $display("FAIL both_dout: got %h expected %h", obs_dout9, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        slave_sel = 2'd3;
        data_in   = 8'hFF;
        write_en  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            MISO = 1'b1;
        end
        rst = 1'b1;
        #1;
        n_total++;
        if ({SS_4, SS_3, SS_2, SS_1} !== 4'hF) $display("FAIL rstmid_ss: got %b expected 1111", {SS_4, SS_3, SS_2, SS_1});
        else n_pass++;
        n_total++;
        if (MOSI !== 1'b0) $display("FAIL rstmid_mosi: got %b expected 0", MOSI);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (sclk !== 1'b0) $display("FAIL rstmid_sclk: got %b expected 0", sclk);
        else n_pass++;
        write_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        n_total++;
        if (data_out !== 8'h00) $display("FAIL rstmid_dout: got %h expected 00", data_out);
        else n_pass++;
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h69);
        do_transfer(2'd0, 8'h96, 1'b1, 1'b0, 8'h69, 2, 1'b0);
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_mosi !== exp_v) $display("FAIL rstmid_after_mosi: got %h expected %h", obs_mosi, exp_v);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_dout9 !== exp_v) $display("FAIL rstmid_after_dout: got %h expected %h", obs_dout9, exp_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back_sel();
        logic [1:0] sels [2];
        logic [7:0] words [2];
        sels[0] = 2'd0;  words[0] = 8'hC3;
        sels[1] = 2'd3;  words[1] = 8'h1E;
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back(words[t]);
            exp_q.push_back(~words[t]);
            do_transfer(sels[t], words[t], 1'b1, 1'b0, ~words[t], 5, 1'b1);
            n_total++;
            if (obs_tgt_low !== 8) $display("FAIL seq%0d_tgt_low: got %0d expected 8", t, obs_tgt_low);
            else n_pass++;
            n_total++;
            if (obs_other_low !== 0) $display("FAIL seq%0d_other_low: got %0d expected 0", t, obs_other_low);
            else n_pass++;
            exp_v = exp_q.pop_front();
            n_total++;
            if (obs_mosi !== exp_v) $display("FAIL seq%0d_mosi: got %h expected %h", t, obs_mosi, exp_v);
            else n_pass++;
            exp_v = exp_q.pop_front();
            n_total++;
            if (obs_dout9 !== exp_v) $display("FAIL seq%0d_dout: got %h expected %h", t, obs_dout9, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        read_en   = 1'b0;
        write_en  = 1'b0;
        MISO      = 1'b0;
        slave_sel = 2'd0;
        data_in   = 8'h00;
        @(posedge clk); #1;
        test_reset();
        @(posedge clk); #1;
        test_write();
        test_hold();
        test_read();
        test_both_enables();
        test_reset_mid();
        test_back_to_back_sel();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
